// File: rtl/rr_grant_sequencer.sv
// Packet-level round-robin grant stage around an external variable-priority arbiter.
// Latches the arbiter's one-hot grant, holds it for a whole packet and muxes the winner onto one channel.
module rr_grant_sequencer #(
  parameter int LENGTH = 4,
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(LENGTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LENGTH-1:0]        req,
  input  logic [LENGTH-1:0]        req_last,
  input  logic [LENGTH*DATA_W-1:0] req_data,
  output logic [LENGTH-1:0]        req_ready,
  output logic [LENGTH-1:0]        arb_priority,
  input  logic [LENGTH-1:0]        arb_gnt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [IDX_W-1:0]         out_src,
  output logic                     gnt_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [LENGTH-1:0]   gnt_q, gnt_d;
  logic [LENGTH-1:0]   prio_q, prio_d;
  logic [IDX_W-1:0]    src_q, src_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_legal;
  logic                busy;
  logic                xfer;
  logic                pkt_end;
  logic [DATA_W-1:0]   data_arr [LENGTH];

  genvar gi;
  generate
    for (gi = 0; gi < LENGTH; gi++) begin : g_slice
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < LENGTH; i++) begin
      if (arb_gnt[i]) gnt_idx = IDX_W'(i);
    end
  end

  // A grant is only trusted if it is one-hot and lands on an active requestor.
  assign gnt_legal = $onehot(arb_gnt) && (|(arb_gnt & req));

  assign busy      = (state_q == BUSY);
  assign out_valid = busy & req[src_q];
  assign out_data  = busy ? data_arr[src_q] : '0;
  assign out_last  = busy & req_last[src_q];
  assign req_ready = gnt_q & {LENGTH{out_ready}};
  assign xfer      = out_valid & out_ready;
  assign pkt_end   = xfer & out_last;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    src_d   = src_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          if (gnt_legal) begin
            gnt_d   = arb_gnt;
            src_d   = gnt_idx;
            state_d = BUSY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (pkt_end) begin
          state_d = IDLE;
          gnt_d   = '0;
          prio_d  = {gnt_q[LENGTH-2:0], gnt_q[LENGTH-1]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      prio_q  <= LENGTH'(1);
      src_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      src_q   <= src_d;
      err_q   <= err_d;
    end
  end

  assign arb_priority = prio_q;
  assign out_src      = src_q;
  assign gnt_err      = err_q;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed bench: a stimulus thread queues expected beats, a monitor pops them on every channel transfer.
// Includes a behavioural variable-priority arbiter with an override for illegal grants.
module tb_rr_grant_sequencer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  arb_priority;
  logic [3:0]  arb_gnt;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_src;
  logic        gnt_err;

  logic        force_en;
  logic [3:0]  force_val;
  logic [3:0]  model_gnt;

  int total;
  int bad;
  int cyc;
  int pop_cnt;
  int rdy1_cnt;
  logic [10:0] exp_q [$];

  rr_grant_sequencer #(.LENGTH(4), .DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .arb_priority (arb_priority),
    .arb_gnt      (arb_gnt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_src      (out_src),
    .gnt_err      (gnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // First requestor at or after the priority position wins.
  always_comb begin
    int p;
    int j;
    logic found;
    p = 0;
    j = 0;
    found = 1'b0;
    model_gnt = 4'b0000;
    for (int i = 0; i < 4; i++) if (arb_priority[i]) p = i;
    for (int k = 0; k < 4; k++) begin
      j = (p + k) % 4;
      if (!found && req[j]) begin
        model_gnt[j] = 1'b1;
        found = 1'b1;
      end
    end
    arb_gnt = force_en ? force_val : model_gnt;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && req_ready[1]) rdy1_cnt++;
  end

  always @(negedge clk) begin
    logic [10:0] e;
    if (rst_n && out_valid && out_ready) begin
      $display("beat src=%0d data=%02h last=%0b", out_src, out_data, out_last);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got src=%0d data=%02h, required no beat", out_src, out_data);
      end else begin
        e = exp_q.pop_front();
        pop_cnt++;
        check("beat_data", 32'(out_data), 32'(e[10:3]));
        check("beat_last", 32'(out_last), 32'(e[2]));
        check("beat_src",  32'(out_src),  32'(e[1:0]));
      end
    end
  end

  task automatic push_exp(input int i, input logic [7:0] d, input logic l);
    exp_q.push_back({d, l, 2'(i)});
  endtask

  task automatic drive_beat(input int i, input logic [7:0] d, input logic l);
    bit ok;
    req[i] = 1'b1;
    req_data[i*8 +: 8] = d;
    req_last[i] = l;
    push_exp(i, d, l);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
    check("beat_accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int last_cyc;
    int p0;
    total = 0; bad = 0; cyc = 0; pop_cnt = 0; rdy1_cnt = 0;
    rst_n = 1'b0; req = '0; req_last = '0; req_data = '0;
    out_ready = 1'b1; force_en = 1'b0; force_val = '0;

    // Reset values
    @(negedge clk);
    check("rst_prio_in_reset", 32'(arb_priority), 32'h1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_prio",   32'(arb_priority), 32'h1);
    check("rst_valid",  32'(out_valid), 32'h0);
    check("rst_ready",  32'(req_ready), 32'h0);
    check("rst_src",    32'(out_src), 32'h0);
    check("rst_err",    32'(gnt_err), 32'h0);
    check("rst_last",   32'(out_last), 32'h0);
    check("rst_data",   32'(out_data), 32'h0);

    // req=0110 under priority 0001: requestor 1 wins, 3-beat packet
    rdy1_cnt = 0;
    @(posedge clk); #1;
    req = 4'b0110;
    req_data[15:8] = 8'h11; req_data[23:16] = 8'h99;
    push_exp(1, 8'h11, 1'b0);
    @(negedge clk);
    check("lat_idle_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1 req[2] = 1'b0;
    @(negedge clk);
    check("grant_valid", 32'(out_valid), 32'h1);
    check("grant_src",   32'(out_src), 32'h1);
    check("grant_ready", 32'(req_ready), 32'b0010);
    check("grant_prio",  32'(arb_priority), 32'h1);
    @(posedge clk); #1;
    drive_beat(1, 8'h22, 1'b0);
    drive_beat(1, 8'h33, 1'b1);
    req = '0; req_last = '0;
    @(negedge clk);
    check("pkt1_idle_valid", 32'(out_valid), 32'h0);
    check("pkt1_idle_ready", 32'(req_ready), 32'h0);
    check("pkt1_prio",       32'(arb_priority), 32'b0100);
    check("pkt1_rdy1_cycles", 32'(rdy1_cnt), 32'd3);

    // Illegal multi-hot grant in IDLE
    @(posedge clk); #1;
    req = 4'b0011; force_en = 1'b1; force_val = 4'b0011;
    @(negedge clk);
    check("err_pre", 32'(gnt_err), 32'h0);
    @(posedge clk); #1;
    req = '0; force_en = 1'b0;
    @(negedge clk);
    check("err_pulse", 32'(gnt_err), 32'h1);
    check("err_ready", 32'(req_ready), 32'h0);
    check("err_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("err_clear", 32'(gnt_err), 32'h0);
    check("err_no_grant", 32'(req_ready), 32'h0);
    check("err_prio", 32'(arb_priority), 32'b0100);

    // Stalled 2-beat packet from requestor 3, ready pattern 1,0,0,1
    p0 = pop_cnt;
    @(posedge clk); #1;
    req[3] = 1'b1; req_data[31:24] = 8'h5A; req_last[3] = 1'b0; out_ready = 1'b1;
    push_exp(3, 8'h5A, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_data[31:24] = 8'hC3; req_last[3] = 1'b1; out_ready = 1'b0;
    push_exp(3, 8'hC3, 1'b1);
    @(negedge clk);
    check("stall1_data",  32'(out_data), 32'hC3);
    check("stall1_valid", 32'(out_valid), 32'h1);
    check("stall1_ready", 32'(req_ready), 32'h0);
    check("stall1_src",   32'(out_src), 32'h3);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall2_data", 32'(out_data), 32'hC3);
    check("stall2_last", 32'(out_last), 32'h1);
    check("stall2_src",  32'(out_src), 32'h3);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_ready", 32'(req_ready), 32'b1000);
    @(posedge clk); #1 req = '0; req_last = '0;
    @(negedge clk);
    check("stall_end_valid", 32'(out_valid), 32'h0);
    check("stall_xfers", 32'(pop_cnt - p0), 32'd2);
    check("stall_prio",  32'(arb_priority), 32'b0001);

    // Continuous single-beat packets from all four requestors
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_last = 4'b1111;
    for (int k = 0; k < 6; k++) push_exp(k % 4, 8'hA0 + 8'(k % 4), 1'b1);
    @(posedge clk); #1 req = 4'b1111;
    seen = 0; last_cyc = 0;
    for (int t = 0; t < 40 && seen < 6; t++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (seen > 0) check("rr_gap", 32'(cyc - last_cyc), 32'd2);
        last_cyc = cyc;
        seen++;
        if (seen == 6) begin
          @(posedge clk); #1 req = '0;
        end
      end else if (seen > 0) begin
        check("rr_prio", 32'(arb_priority), 32'(4'b0001 << (seen % 4)));
      end
    end
    check("rr_count", 32'(seen), 32'd6);
    req_last = '0;
    @(negedge clk);
    check("rr_end_prio", 32'(arb_priority), 32'b0100);

    // Reset during beat 2 of a 4-beat packet from requestor 3
    @(posedge clk); #1;
    req[3] = 1'b1; req_data[31:24] = 8'h01; req_last[3] = 1'b0;
    push_exp(3, 8'h01, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_beat1_valid", 32'(out_valid), 32'h1);
    @(posedge clk); #1;
    req_data[31:24] = 8'h02;
    push_exp(3, 8'h02, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    exp_q.delete();
    req = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_prio", 32'(arb_priority), 32'b0001);
    check("mid_rst_src",  32'(out_src), 32'h0);

    // Fresh packet after reset is not a resumed one
    @(posedge clk); #1;
    drive_beat(0, 8'h77, 1'b1);
    req = '0; req_last = '0;
    @(negedge clk);
    check("post_rst_prio", 32'(arb_priority), 32'b0010);
    check("q_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
